multicycle_datapath: RTL and testbench

Datapath end of the multicycle RV32I core's control interface. Consumes the per-cycle control strobes from the core FSM, holds all architectural and non-architectural state (PC, OldPC, IR, Data, A, B, ALUOut, register file), and drives a unified instruction/data memory port. Returns decode fields (`op`, `funct3`, `funct7[5]`) and the ALU `zero` flag to the controller.

---
 rtl/riscv_pkg.sv | 50 +++++
 rtl/multicycle_datapath_if.sv | 24 ++
 rtl/multicycle_datapath_reg_file.sv | 38 +++
 rtl/multicycle_datapath.sv | 157 +++++++++++++++
 tb/tb_multicycle_datapath.sv | 369 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared types and constants for the multicycle RV32I datapath.
// Selector enums mirror the controller's strobe encodings.
package riscv_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_op_e;

  typedef enum logic [1:0] {
    SRC_A_PC    = 2'b00,
    SRC_A_OLDPC = 2'b01,
    SRC_A_REG   = 2'b10,
    SRC_A_ZERO  = 2'b11
  } src_a_e;

  typedef enum logic [1:0] {
    SRC_B_REG  = 2'b00,
    SRC_B_IMM  = 2'b01,
    SRC_B_FOUR = 2'b10,
    SRC_B_ZERO = 2'b11
  } src_b_e;

  typedef enum logic [1:0] {
    RES_ALUOUT  = 2'b00,
    RES_DATA    = 2'b01,
    RES_ALU     = 2'b10,
    RES_ALUOUT2 = 2'b11
  } result_src_e;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_J = 2'b11
  } imm_src_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/multicycle_datapath_if.sv
// Unified instruction/data memory port of the multicycle datapath.
// master = datapath side, slave = memory side.
interface multicycle_datapath_if;

  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic [31:0] rdata;

  modport master (
    output addr,
    output wdata,
    output we,
    input  rdata
  );

  modport slave (
    input  addr,
    input  wdata,
    input  we,
    output rdata
  );

endinterface

// File: rtl/multicycle_datapath_reg_file.sv
// 32x32 register file, combinational reads, x0 hardwired to zero.
// DATAPATH_DEBUG_PORT_EN adds a third read port.
module reg_file (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
`ifdef DATAPATH_DEBUG_PORT_EN
  input  logic [4:0]  ra3,
  output logic [31:0] rd3,
`endif
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd
);

  logic [31:0] regs [32];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else if (we && wa != 5'd0) begin
      regs[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == 5'd0) ? '0 : regs[ra1];
  assign rd2 = (ra2 == 5'd0) ? '0 : regs[ra2];

`ifdef DATAPATH_DEBUG_PORT_EN
  assign rd3 = (ra3 == 5'd0) ? '0 : regs[ra3];
`endif

endmodule

// File: rtl/multicycle_datapath.sv
// Multicycle RV32I datapath: state registers, ALU, immediates, memory port.
// DATAPATH_DEBUG_PORT_EN adds dbg_addr_i/dbg_data_o register peek port.
module multicycle_datapath
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        pc_write_i,
  input  logic        addr_src_i,
  input  logic        mem_write_i,
  input  logic        ir_write_i,
  input  logic [1:0]  result_src_i,
  input  logic [2:0]  alu_control_i,
  input  logic [1:0]  alu_src_a_i,
  input  logic [1:0]  alu_src_b_i,
  input  logic [1:0]  imm_src_i,
  input  logic        reg_write_i,
  output logic [6:0]  op_o,
  output logic [2:0]  funct3_o,
  output logic        funct7_o,
  output logic        zero_o,
  multicycle_datapath_if.master mem
`ifdef DATAPATH_DEBUG_PORT_EN
  ,
  input  logic [4:0]  dbg_addr_i,
  output logic [31:0] dbg_data_o
`endif
);

  logic [31:0] pc_q;
  logic [31:0] old_pc_q;
  logic [31:0] ir_q;
  logic [31:0] data_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] alu_out_q;

  logic [31:0] rd1;
  logic [31:0] rd2;
  logic [31:0] imm_ext;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [31:0] alu_res;
  logic [31:0] result;

  reg_file u_reg_file (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .ra1   (ir_q[19:15]),
    .ra2   (ir_q[24:20]),
    .rd1   (rd1),
    .rd2   (rd2),
`ifdef DATAPATH_DEBUG_PORT_EN
    .ra3   (dbg_addr_i),
    .rd3   (dbg_data_o),
`endif
    .we    (reg_write_i),
    .wa    (ir_q[11:7]),
    .wd    (result)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pc_q      <= RESET_PC;
      old_pc_q  <= '0;
      ir_q      <= NOP_INSTR;
      data_q    <= '0;
      a_q       <= '0;
      b_q       <= '0;
      alu_out_q <= '0;
    end else begin
      if (pc_write_i) begin
        pc_q <= result;
      end
      if (ir_write_i) begin
        ir_q     <= mem.rdata;
        old_pc_q <= pc_q;
      end
      data_q    <= mem.rdata;
      a_q       <= rd1;
      b_q       <= rd2;
      alu_out_q <= alu_res;
    end
  end

  always_comb begin
    imm_ext = '0;
    unique case (imm_src_e'(imm_src_i))
      IMM_I: imm_ext = {{20{ir_q[31]}}, ir_q[31:20]};
      IMM_S: imm_ext = {{20{ir_q[31]}}, ir_q[31:25],
                        ir_q[11:7]};
      IMM_B: imm_ext = {{19{ir_q[31]}}, ir_q[31], ir_q[7],
                        ir_q[30:25], ir_q[11:8], 1'b0};
      IMM_J: imm_ext = {{11{ir_q[31]}}, ir_q[31],
                        ir_q[19:12], ir_q[20],
                        ir_q[30:21], 1'b0};
      default: imm_ext = '0;
    endcase
  end

  always_comb begin
    src_a = '0;
    unique case (src_a_e'(alu_src_a_i))
      SRC_A_PC:    src_a = pc_q;
      SRC_A_OLDPC: src_a = old_pc_q;
      SRC_A_REG:   src_a = a_q;
      SRC_A_ZERO:  src_a = '0;
      default:     src_a = '0;
    endcase
  end

  always_comb begin
    src_b = '0;
    unique case (src_b_e'(alu_src_b_i))
      SRC_B_REG:  src_b = b_q;
      SRC_B_IMM:  src_b = imm_ext;
      SRC_B_FOUR: src_b = 32'd4;
      SRC_B_ZERO: src_b = '0;
      default:    src_b = '0;
    endcase
  end

  // Unassigned ALU codes deliberately produce zero.
  always_comb begin
    alu_res = '0;
    unique case (alu_op_e'(alu_control_i))
      ALU_ADD: alu_res = src_a + src_b;
      ALU_SUB: alu_res = src_a - src_b;
      ALU_AND: alu_res = src_a & src_b;
      ALU_OR:  alu_res = src_a | src_b;
      ALU_SLT: alu_res = {31'd0,
                          $signed(src_a) < $signed(src_b)};
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    result = alu_out_q;
    unique case (result_src_e'(result_src_i))
      RES_DATA: result = data_q;
      RES_ALU:  result = alu_res;
      default:  result = alu_out_q;
    endcase
  end

  assign zero_o   = (alu_res == 32'd0);
  assign op_o     = ir_q[6:0];
  assign funct3_o = ir_q[14:12];
  assign funct7_o = ir_q[30];

  assign mem.addr  = addr_src_i ? result : pc_q;
  assign mem.wdata = b_q;
  assign mem.we    = mem_write_i & rst_ni;

endmodule

// File: tb/tb_multicycle_datapath.sv
// Directed bench for multicycle_datapath.
// Define DATAPATH_DEBUG_PORT_EN to also exercise the debug read port.
module tb_multicycle_datapath;

  localparam logic [31:0] RPC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pc_write;
  logic        addr_src;
  logic        mem_write;
  logic        ir_write;
  logic [1:0]  result_src;
  logic [2:0]  alu_ctl;
  logic [1:0]  src_a;
  logic [1:0]  src_b;
  logic [1:0]  imm_src;
  logic        reg_write;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7;
  logic        zero;
`ifdef DATAPATH_DEBUG_PORT_EN
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;
`endif

  multicycle_datapath_if mem_bus();

  always #5 clk = ~clk;

  multicycle_datapath #(.RESET_PC(RPC)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .pc_write_i   (pc_write),
    .addr_src_i   (addr_src),
    .mem_write_i  (mem_write),
    .ir_write_i   (ir_write),
    .result_src_i (result_src),
    .alu_control_i(alu_ctl),
    .alu_src_a_i  (src_a),
    .alu_src_b_i  (src_b),
    .imm_src_i    (imm_src),
    .reg_write_i  (reg_write),
    .op_o         (op),
    .funct3_o     (funct3),
    .funct7_o     (funct7),
    .zero_o       (zero),
    .mem          (mem_bus.master)
`ifdef DATAPATH_DEBUG_PORT_EN
    ,
    .dbg_addr_i   (dbg_addr),
    .dbg_data_o   (dbg_data)
`endif
  );

  typedef struct {
    logic [2:0]  alu;
    logic [1:0]  sa;
    logic [1:0]  sb;
    logic [31:0] res;
    logic        z;
  } alu_vec_t;

  typedef struct {
    logic [31:0] ir;
    logic [1:0]  sel;
    logic [31:0] imm;
  } imm_vec_t;

  alu_vec_t    alu_tab [13];
  imm_vec_t    imm_tab [6];
  int          n_chk;
  int          n_fail;
  logic [31:0] exp_pc;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  task automatic idle();
    pc_write   = 1'b0;
    addr_src   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    result_src = 2'b10;
    alu_ctl    = 3'b000;
    src_a      = 2'b11;
    src_b      = 2'b11;
    imm_src    = 2'b00;
    reg_write  = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Observe ALUResult on the address bus.
  task automatic alu_view(input logic [2:0] a,
                          input logic [1:0] sa,
                          input logic [1:0] sb);
    alu_ctl    = a;
    src_a      = sa;
    src_b      = sb;
    result_src = 2'b10;
    addr_src   = 1'b1;
    #1;
  endtask

  task automatic fetch(input logic [31:0] w);
    idle();
    mem_bus.rdata = w;
    ir_write = 1'b1;
    pc_write = 1'b1;
    src_a    = 2'b00;
    src_b    = 2'b10;
    #1;
    chk("fetch_pc", mem_bus.addr, exp_pc);
    step();
    exp_pc = exp_pc + 32'd4;
    idle();
  endtask

  // decode, execute A+immI, ALUOut writeback
  task automatic run_itype(input logic [31:0] w);
    fetch(w);
    step();
    src_a = 2'b10;
    src_b = 2'b01;
    step();
    idle();
    result_src = 2'b00;
    reg_write  = 1'b1;
    step();
    idle();
  endtask

  task automatic store(input logic [31:0] wd,
                       input bit do_rst);
    fetch(32'h0010_2423);
    step();
    src_a   = 2'b10;
    src_b   = 2'b01;
    imm_src = 2'b01;
    step();
    idle();
    addr_src   = 1'b1;
    result_src = 2'b00;
    mem_write  = 1'b1;
    #1;
    chk("sw_addr", mem_bus.addr, 32'd8);
    chk("sw_wdata", mem_bus.wdata, wd);
    chk("sw_we", {31'd0, mem_bus.we}, 32'd1);
    if (do_rst) begin
      rst_n = 1'b0;
      #1;
      chk("rst_we", {31'd0, mem_bus.we}, 32'd0);
      step();
      chk("rst_we_edge", {31'd0, mem_bus.we}, 32'd0);
      rst_n  = 1'b1;
      exp_pc = RPC;
    end else begin
      step();
    end
    idle();
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    exp_pc = RPC;

    // A = x3 = -1, B = x4 = 1, immI = 4,
    // OldPC = 0x114, PC = 0x118
    alu_tab[0]  = '{3'b000, 2'b10, 2'b00, 32'h0, 1'b1};
    alu_tab[1]  = '{3'b001, 2'b10, 2'b00, 32'hFFFF_FFFE, 1'b0};
    alu_tab[2]  = '{3'b010, 2'b10, 2'b00, 32'h1, 1'b0};
    alu_tab[3]  = '{3'b011, 2'b10, 2'b00, 32'hFFFF_FFFF, 1'b0};
    alu_tab[4]  = '{3'b101, 2'b10, 2'b00, 32'h1, 1'b0};
    alu_tab[5]  = '{3'b101, 2'b00, 2'b10, 32'h0, 1'b1};
    alu_tab[6]  = '{3'b100, 2'b10, 2'b00, 32'h0, 1'b1};
    alu_tab[7]  = '{3'b111, 2'b10, 2'b00, 32'h0, 1'b1};
    alu_tab[8]  = '{3'b110, 2'b10, 2'b00, 32'h0, 1'b1};
    alu_tab[9]  = '{3'b000, 2'b01, 2'b10, 32'h118, 1'b0};
    alu_tab[10] = '{3'b000, 2'b00, 2'b11, 32'h118, 1'b0};
    alu_tab[11] = '{3'b000, 2'b10, 2'b01, 32'h3, 1'b0};
    alu_tab[12] = '{3'b001, 2'b11, 2'b11, 32'h0, 1'b1};

    imm_tab[0] = '{32'hFFDF_F06F, 2'b11, 32'hFFFF_FFFC};
    imm_tab[1] = '{32'hFFDF_F06F, 2'b00, 32'hFFFF_FFFD};
    imm_tab[2] = '{32'hFFDF_F06F, 2'b01, 32'hFFFF_FFE0};
    imm_tab[3] = '{32'hFE20_8CE3, 2'b10, 32'hFFFF_FFF8};
    imm_tab[4] = '{32'hFE20_8CE3, 2'b00, 32'hFFFF_FFE2};
    imm_tab[5] = '{32'h0010_2423, 2'b01, 32'h0000_0008};

    idle();
    mem_bus.rdata = 32'h0;
    rst_n = 1'b0;
`ifdef DATAPATH_DEBUG_PORT_EN
    dbg_addr = 5'd0;
`endif
    step();
    step();
    rst_n = 1'b1;
    #1;
    chk("rst_addr", mem_bus.addr, RPC);
    chk("rst_op", {25'd0, op}, 32'h13);
    chk("rst_f3", {29'd0, funct3}, 32'd0);
    chk("rst_f7", {31'd0, funct7}, 32'd0);
    chk("rst_we", {31'd0, mem_bus.we}, 32'd0);
    chk("rst_wdata", mem_bus.wdata, 32'd0);

    // addi x1,x0,5 fetch edge: PC, OldPC, IR together
    fetch(32'h0050_0093);
    chk("f_op", {25'd0, op}, 32'h13);
    chk("f_pc", mem_bus.addr, 32'h104);
    alu_view(3'b000, 2'b01, 2'b11);
    chk("f_oldpc", mem_bus.addr, 32'h100);
    idle();
    step();
    src_a = 2'b10;
    src_b = 2'b01;
    step();
    idle();
    result_src = 2'b00;
    reg_write  = 1'b1;
    step();
    idle();

    run_itype(32'h0050_0113);
    run_itype(32'hFFF0_0193);
    run_itype(32'h0010_0213);
    run_itype(32'h0070_0013);

`ifdef DATAPATH_DEBUG_PORT_EN
    dbg_addr = 5'd1;
    #1;
    chk("dbg_x1", dbg_data, 32'd5);
    dbg_addr = 5'd0;
    #1;
    chk("dbg_x0", dbg_data, 32'd0);
`endif

    // add x0,x3,x4
    fetch(32'h0041_8033);
    chk("r_op", {25'd0, op}, 32'h33);
    step();
    for (int i = 0; i < 13; i++) begin
      alu_view(alu_tab[i].alu, alu_tab[i].sa,
               alu_tab[i].sb);
      chk($sformatf("alu[%0d]", i), mem_bus.addr,
          alu_tab[i].res);
      chk($sformatf("zero[%0d]", i), {31'd0, zero},
          {31'd0, alu_tab[i].z});
    end

    // add x0,x0,x1: x0 write was dropped, x1 holds 5
    fetch(32'h0010_0033);
    step();
    alu_view(3'b000, 2'b10, 2'b11);
    chk("x0_read", mem_bus.addr, 32'd0);
    alu_view(3'b000, 2'b11, 2'b00);
    chk("x1_read", mem_bus.addr, 32'd5);

    // sub x0,x1,x2: BEQ condition
    fetch(32'h4020_8033);
    chk("sub_f7", {31'd0, funct7}, 32'd1);
    step();
    alu_view(3'b001, 2'b10, 2'b00);
    chk("beq_zero", {31'd0, zero}, 32'd1);

    for (int i = 0; i < 6; i++) begin
      fetch(imm_tab[i].ir);
      imm_src = imm_tab[i].sel;
      alu_view(3'b000, 2'b11, 2'b01);
      chk($sformatf("imm[%0d]", i), mem_bus.addr,
          imm_tab[i].imm);
    end

    store(32'd5, 1'b0);

    // addi x1,x1,1: rd == rs1 read-during-write
    fetch(32'h0010_8093);
    step();
    src_a = 2'b10;
    src_b = 2'b01;
    step();
    idle();
    result_src = 2'b00;
    reg_write  = 1'b1;
    addr_src   = 1'b1;
    #1;
    chk("wb_result", mem_bus.addr, 32'd6);
    step();
    idle();
    alu_view(3'b000, 2'b10, 2'b11);
    chk("raw_old", mem_bus.addr, 32'd5);
    step();
    chk("raw_new", mem_bus.addr, 32'd6);
    idle();

    // lw x5,4(x0) then observe x5
    fetch(32'h0040_2283);
    step();
    src_a = 2'b10;
    src_b = 2'b01;
    step();
    idle();
    addr_src      = 1'b1;
    result_src    = 2'b00;
    mem_bus.rdata = 32'hDEAD_BEEF;
    #1;
    chk("lw_addr", mem_bus.addr, 32'd4);
    step();
    mem_bus.rdata = 32'h0;
    result_src    = 2'b01;
    reg_write     = 1'b1;
    #1;
    chk("lw_data", mem_bus.addr, 32'hDEAD_BEEF);
    step();
    idle();
    fetch(32'h0002_8033);
    step();
    alu_view(3'b000, 2'b10, 2'b11);
    chk("lw_x5", mem_bus.addr, 32'hDEAD_BEEF);
    idle();

`ifdef DATAPATH_DEBUG_PORT_EN
    dbg_addr = 5'd5;
    #1;
    chk("dbg_x5", dbg_data, 32'hDEAD_BEEF);
`endif

    // store interrupted by reset
    store(32'd6, 1'b1);
    #1;
    chk("rst2_addr", mem_bus.addr, RPC);
    chk("rst2_op", {25'd0, op}, 32'h13);
    fetch(32'h0020_8033);
    step();
    alu_view(3'b000, 2'b10, 2'b11);
    chk("rst2_x1", mem_bus.addr, 32'd0);
    alu_view(3'b000, 2'b11, 2'b00);
    chk("rst2_x2", mem_bus.addr, 32'd0);
    idle();

`ifdef DATAPATH_DEBUG_PORT_EN
    for (int r = 0; r < 32; r++) begin
      dbg_addr = 5'(r);
      #1;
      chk($sformatf("rst2_dbg[%0d]", r), dbg_data,
          32'd0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
